uart_tx_fifo: RTL and testbench

//  Buffered front end for uart_tx: accepts bytes from the host side into a circular FIFO.

---
 rtl/uart_tx_fifo.sv | 110 +++++++++++
 tb/tb_uart_tx_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of uart_tx: buffers host writes and hands one word per frame to the
// transmitter, pacing sends from the transmitter's active/done status.
module uart_tx_fifo #(
    parameter int p_WORD_LEN = 8,
    parameter int p_DEPTH    = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_wr_en,
    input  logic [p_WORD_LEN-1:0]        i_wr_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(p_DEPTH+1)-1:0] o_count,
    output logic                         o_overflow,
    output logic                         o_busy,
    output logic                         o_send,
    output logic [p_WORD_LEN-1:0]        o_data,
    input  logic                         i_tx_active,
    input  logic                         i_tx_done
);

    localparam int c_PTR_W = $clog2(p_DEPTH);
    localparam int c_CNT_W = $clog2(p_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(p_DEPTH);

    typedef enum logic [2:0] {
        s_DRAIN,
        s_IDLE,
        s_SEND,
        s_WAIT_ACT,
        s_WAIT_DONE
    } state_t;

    // Exposed for checkers that bind to this block.
    state_t state;
    state_t state_next;

    logic [p_WORD_LEN-1:0] mem [p_DEPTH];
    logic [c_PTR_W-1:0]    wr_ptr;
    logic [c_PTR_W-1:0]    rd_ptr;
    logic [c_CNT_W-1:0]    count;
    logic                  pop;
    logic                  wr_accept;
    logic                  wr_drop;

    // Handshakes: i_wr_en is a one-cycle valid with no ready; a write while full and not
    // popping is dropped and flagged on o_overflow the next cycle. o_send is a one-cycle
    // strobe; the transmitter taking it is seen as i_tx_active rising.
    assign o_full    = (count == c_FULL);
    assign o_empty   = (count == '0);
    assign o_count   = count;
    assign pop       = (state == s_IDLE) && !o_empty;
    assign wr_accept = i_wr_en && (!o_full || pop);
    assign wr_drop   = i_wr_en && !wr_accept;
    assign o_busy    = (state != s_IDLE) || !o_empty;

    always_comb begin
        state_next = state;
        o_send     = 1'b0;
        case (state)
            s_DRAIN: begin
                if (!i_tx_active && !i_tx_done) state_next = s_IDLE;
            end
            s_IDLE: begin
                if (!o_empty) state_next = s_SEND;
            end
            s_SEND: begin
                o_send     = 1'b1;
                state_next = s_WAIT_ACT;
            end
            s_WAIT_ACT: begin
                if (i_tx_active) state_next = s_WAIT_DONE;
            end
            s_WAIT_DONE: begin
                // Settle in s_DRAIN so the second cycle of the done pulse is waited out.
                if (i_tx_done) state_next = s_DRAIN;
            end
            default: state_next = s_DRAIN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (wr_accept) mem[wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= s_DRAIN;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
            o_data     <= '0;
        end else begin
            state      <= state_next;
            o_overflow <= wr_drop;
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                o_data <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a behavioural transmitter responder plus an ordered scoreboard of
// accepted words, with timing rules for latency, send pacing and data stability.
module tb_uart_tx_fifo;
    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [W-1:0]  wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          busy;
    logic          send;
    logic [W-1:0]  data;
    logic          tx_act;
    logic          tx_hold;
    logic          tx_done;
    logic          tx_active_line;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sends = 0;
    int last_send_cyc = 0;
    int last_fall_cyc = -100;
    int accepted_total = 0;
    int discarded = 0;
    bit resp_busy = 1'b0;
    bit frame_reset = 1'b0;

    logic [W-1:0] exp_q[$];

    assign tx_active_line = tx_act | tx_hold;

    uart_tx_fifo #(.p_WORD_LEN(W), .p_DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_en     (wr_en),
        .i_wr_data   (wr_data),
        .o_full      (full),
        .o_empty     (empty),
        .o_count     (count),
        .o_overflow  (overflow),
        .o_busy      (busy),
        .o_send      (send),
        .o_data      (data),
        .i_tx_active (tx_active_line),
        .i_tx_done   (tx_done)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Transmitter model: active for a frame after each send, then done high for 2 cycles.
    initial begin
        logic [W-1:0] cap;
        int frame_len;
        tx_act  = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (send === 1'b1) begin
                sends++;
                last_send_cyc = cyc;
                resp_busy     = 1'b1;
                frame_reset   = 1'b0;
                check_eq("send_pacing", 32'(cyc - last_fall_cyc >= 2), 1);
                if (exp_q.size() == 0) check_eq("send_unexpected", send, 0);
                else check_eq("send_data", data, exp_q.pop_front());
                cap       = data;
                frame_len = 8 + $urandom_range(0, 4);
                @(negedge clk);
                tx_act = 1'b1;
                check_eq("send_width", send, 0);
                repeat (frame_len) begin
                    @(negedge clk);
                    check_eq("send_in_frame", send, 0);
                    if (!frame_reset) check_eq("data_stable", data, cap);
                end
                tx_act  = 1'b0;
                tx_done = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    check_eq("send_in_done", send, 0);
                end
                tx_done       = 1'b0;
                last_fall_cyc = cyc;
                resp_busy     = 1'b0;
            end
        end
    end

    // Driver tasks: entered and left on a falling edge.
    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        discarded += exp_q.size();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic write_word(input logic [W-1:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) begin
            exp_q.push_back(d);
            accepted_total++;
        end
        @(negedge clk);
        wr_en = 1'b0;
        check_eq("overflow", overflow, {31'b0, !accept});
    endtask

    task automatic wait_sends(input int target, input string tag);
        for (int i = 0; i < 3000 && sends < target; i++) @(negedge clk);
        check_eq(tag, sends, target);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 4000 && (exp_q.size() != 0 || resp_busy || empty !== 1'b1); i++)
            @(negedge clk);
        check_eq({tag, "_queue"}, exp_q.size(), 0);
        check_eq({tag, "_idle"}, resp_busy, 0);
        check_eq({tag, "_empty"}, empty, 1);
    endtask

    initial begin
        int t0;
        int s0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        tx_hold = 1'b0;

        // Reset state and single-word latency
        do_reset();
        check_eq("rst_send", send, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_data", data, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_busy", busy, 1);
        @(negedge clk);
        check_eq("busy_idle", busy, 0);
        t0 = cyc;
        write_word(8'hA5, 1'b1);
        wait_sends(1, "t1_send");
        check_eq("t1_latency", last_send_cyc - t0, 2);
        wait_drain("t1");

        // Back-to-back burst, one send per frame
        s0 = sends;
        for (int i = 1; i <= 5; i++) write_word(8'(i), 1'b1);
        wait_sends(s0 + 5, "t2_sends");
        wait_drain("t2");

        // Fill while the transmitter is held busy, then overflow
        tx_hold = 1'b1;
        do_reset();
        for (int i = 0; i < DEPTH; i++) write_word(8'($urandom_range(0, 254)), 1'b1);
        check_eq("t3_count", count, DEPTH);
        check_eq("t3_full", full, 1);
        write_word(8'hFF, 1'b0);
        check_eq("t3_count_kept", count, DEPTH);
        @(negedge clk);
        check_eq("t3_overflow_pulse", overflow, 0);

        // Write on the pop cycle while full is accepted
        tx_hold = 1'b0;
        @(negedge clk);
        write_word(8'h5A, 1'b1);
        check_eq("t4_count", count, DEPTH);
        check_eq("t4_full", full, 1);
        wait_drain("t4");

        // Reset mid-frame with 3 words queued
        for (int i = 0; i < 4; i++) write_word(8'h10 + 8'(i), 1'b1);
        for (int i = 0; i < 200 && !(resp_busy && tx_act); i++) @(negedge clk);
        check_eq("t5_in_frame", tx_act, 1);
        check_eq("t5_count", count, 3);
        frame_reset = 1'b1;
        s0 = sends;
        do_reset();
        check_eq("t5_count_rst", count, 0);
        check_eq("t5_empty_rst", empty, 1);
        for (int i = 0; i < 200 && resp_busy; i++) @(negedge clk);
        repeat (8) @(negedge clk);
        check_eq("t5_no_send", sends, s0);
        write_word(8'hC3, 1'b1);
        wait_sends(s0 + 1, "t5_resume");
        wait_drain("t5");

        // Stream 0..39 with random gaps, writer holds off while full
        s0 = sends;
        for (int v = 0; v < 40; v++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            for (int k = 0; k < 2000 && full; k++) @(negedge clk);
            write_word(8'(v), 1'b1);
        end
        wait_sends(s0 + 40, "t6_sends");
        wait_drain("t6");

        check_eq("total_sends", sends, accepted_total - discarded);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
